// File: rtl/player_motion_ctrl.sv
// Player sprite motion: per-key held state, paced horizontal stepping,
// and a ground/rise/fall jump sequencer clamped to the playfield.
module player_motion_ctrl #(
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 1000,
    parameter int X_INIT      = 40,
    parameter int Y_GROUND    = 100,
    parameter int STEP_DIV    = 10,
    parameter int JUMP_HEIGHT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [6:0]  key_code,
    input  logic        released,
    input  logic        tick,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        facing_left,
    output logic        airborne
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } jump_state_e;

    localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int RW = $clog2(JUMP_HEIGHT + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [RW-1:0] JH_C     = RW'(JUMP_HEIGHT);
    localparam logic [11:0]   XMIN_C   = 12'(X_MIN);
    localparam logic [11:0]   XMAX_C   = 12'(X_MAX);
    localparam logic [11:0]   XINIT_C  = 12'(X_INIT);
    localparam logic [11:0]   YGND_C   = 12'(Y_GROUND);

    jump_state_e state_q, state_d;
    logic          right_q, right_d;
    logic          left_q, left_d;
    logic          req_q, req_d;
    logic [DW-1:0] div_q, div_d;
    logic [RW-1:0] rise_q, rise_d;
    logic [11:0]   x_q, x_d;
    logic [11:0]   y_q, y_d;
    logic          face_q, face_d;
    logic          air_q, air_d;

    logic is_right, is_left, is_jump;
    logic go_right, go_left;

    always_comb begin
        is_right = (key_code == 7'h44) || (key_code == 7'h64);
        is_left  = (key_code == 7'h41) || (key_code == 7'h61);
        is_jump  = (key_code == 7'h57) || (key_code == 7'h77)
                || (key_code == 7'h20);
        go_right = right_q && !left_q;
        go_left  = left_q && !right_q;
    end

    always_comb begin
        state_d = state_q;
        right_d = right_q;
        left_d  = left_q;
        req_d   = req_q;
        div_d   = div_q;
        rise_d  = rise_q;
        x_d     = x_q;
        y_d     = y_q;
        face_d  = face_q;

        if (key_valid && is_right) right_d = !released;
        if (key_valid && is_left)  left_d  = !released;

        if (tick) begin
            if (!go_right && !go_left) begin
                div_d = '0;
            end else if (div_q == DIV_LAST) begin
                div_d  = '0;
                face_d = go_left;
                if (go_right)
                    x_d = (x_q >= XMAX_C) ? XMAX_C : x_q + 12'd1;
                else
                    x_d = (x_q <= XMIN_C) ? XMIN_C : x_q - 12'd1;
            end else begin
                div_d = div_q + DW'(1);
            end

            unique case (state_q)
                GROUND: begin
                    if (req_q) begin
                        state_d = RISE;
                        req_d   = 1'b0;
                        rise_d  = '0;
                    end
                end
                RISE: begin
                    y_d    = y_q - 12'd1;
                    rise_d = rise_q + RW'(1);
                    if (rise_q + RW'(1) == JH_C) state_d = FALL;
                end
                FALL: begin
                    y_d = y_q + 12'd1;
                    if (y_q + 12'd1 == YGND_C) state_d = GROUND;
                end
                default: state_d = GROUND;
            endcase
        end

        // A request being consumed this tick wins over a coincident press
        if (key_valid && !released && is_jump && state_q == GROUND
            && !(tick && req_q))
            req_d = 1'b1;

        air_d = (state_d != GROUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GROUND;
            right_q <= 1'b0;
            left_q  <= 1'b0;
            req_q   <= 1'b0;
            div_q   <= '0;
            rise_q  <= '0;
            x_q     <= XINIT_C;
            y_q     <= YGND_C;
            face_q  <= 1'b0;
            air_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            right_q <= right_d;
            left_q  <= left_d;
            req_q   <= req_d;
            div_q   <= div_d;
            rise_q  <= rise_d;
            x_q     <= x_d;
            y_q     <= y_d;
            face_q  <= face_d;
            air_q   <= air_d;
        end
    end

    assign xpos        = x_q;
    assign ypos        = y_q;
    assign facing_left = face_q;
    assign airborne    = air_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: spec-level model checked every cycle
// plus directed literal expectations from the test plan.
module tb_player_motion_ctrl;

    localparam int XMN = 0;
    localparam int XMX = 1000;
    localparam int XI  = 40;
    localparam int YG  = 100;
    localparam int SD  = 10;
    localparam int JH  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [6:0]  key_code = 7'h00;
    logic        released = 1'b0;
    logic        tick = 1'b0;
    logic [11:0] xpos, ypos;
    logic        facing_left, airborne;

    int cmp_n = 0;
    int err_n = 0;

    player_motion_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .released   (released),
        .tick       (tick),
        .xpos       (xpos),
        .ypos       (ypos),
        .facing_left(facing_left),
        .airborne   (airborne)
    );

    always #5 clk = ~clk;

    // Model: position as plain integers, jump as "ticks since takeoff"
    int m_x, m_y, m_cnt, m_age;
    bit m_fl, m_air, m_r, m_l, m_req, started;

    function automatic int y_of_age(int a);
        if (a == 0)          return YG;
        else if (a <= JH + 1) return YG - (a - 1);
        else                 return YG - JH + (a - JH - 1);
    endfunction

    always @(posedge clk) begin
        int dir;
        bit ground_before, consumed;
        started = 1'b1;
        if (rst) begin
            m_x = XI; m_y = YG; m_cnt = 0; m_age = 0;
            m_fl = 0; m_air = 0; m_r = 0; m_l = 0; m_req = 0;
        end else begin
            ground_before = (m_age == 0);
            consumed = 0;
            if (tick) begin
                dir = (m_r && !m_l) ? 1 : (m_l && !m_r) ? -1 : 0;
                if (dir == 0) m_cnt = 0;
                else begin
                    m_cnt++;
                    if (m_cnt == SD) begin
                        m_cnt = 0;
                        m_x = m_x + dir;
                        if (m_x < XMN) m_x = XMN;
                        if (m_x > XMX) m_x = XMX;
                        m_fl = (dir < 0);
                    end
                end
                if (m_age == 0) begin
                    if (m_req) begin m_age = 1; m_req = 0; consumed = 1; end
                end else begin
                    m_age++;
                    if (m_age == 2 * JH + 1) m_age = 0;
                end
                m_y = y_of_age(m_age);
                m_air = (m_age != 0);
            end
            if (key_valid) begin
                case (key_code)
                    7'h44, 7'h64: m_r = !released;
                    7'h41, 7'h61: m_l = !released;
                    7'h57, 7'h77, 7'h20:
                        if (!released && ground_before && !consumed) m_req = 1;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cmp_n += 4;
            if (xpos != 12'(m_x)) begin
                err_n++;
                $display("FAIL model_xpos t=%0t got %0d want %0d", $time, xpos, m_x);
            end
            if (ypos != 12'(m_y)) begin
                err_n++;
                $display("FAIL model_ypos t=%0t got %0d want %0d", $time, ypos, m_y);
            end
            if (facing_left != m_fl) begin
                err_n++;
                $display("FAIL model_face t=%0t got %0d want %0d", $time, facing_left, m_fl);
            end
            if (airborne != m_air) begin
                err_n++;
                $display("FAIL model_air t=%0t got %0d want %0d", $time, airborne, m_air);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        cmp_n++;
        if (act != exp) begin
            err_n++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic key(input logic [6:0] c, input logic r);
        @(negedge clk);
        key_valid = 1'b1; key_code = c; released = r;
        @(negedge clk) key_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_x", xpos, 40);
        chk("rst_y", ypos, 100);
        chk("rst_air", airborne, 0);
        chk("rst_face", facing_left, 0);
        do_ticks(50);
        chk("idle_x", xpos, 40);
        chk("idle_y", ypos, 100);

        key(7'h64, 1'b0);
        do_ticks(20);
        chk("right20_x", xpos, 42);
        do_ticks(5);
        chk("right25_x", xpos, 42);
        key(7'h64, 1'b1);
        do_ticks(10);
        chk("rel_x", xpos, 42);
        chk("rel_face", facing_left, 0);

        key(7'h41, 1'b0);
        key(7'h64, 1'b0);
        do_ticks(30);
        chk("both_x", xpos, 42);
        key(7'h64, 1'b1);
        do_ticks(9);
        chk("left9_x", xpos, 42);
        do_ticks(1);
        chk("left10_x", xpos, 41);
        chk("left10_face", facing_left, 1);
        key(7'h41, 1'b1);

        do_reset();
        key(7'h61, 1'b0);
        do_ticks(399);
        chk("sat399_x", xpos, 1);
        do_ticks(1);
        chk("sat400_x", xpos, 0);
        do_ticks(100);
        chk("sat500_x", xpos, 0);
        key(7'h61, 1'b1);

        do_reset();
        key(7'h20, 1'b0);
        key(7'h20, 1'b1);
        do_ticks(1);
        chk("jump1_air", airborne, 1);
        chk("jump1_y", ypos, 100);
        do_ticks(9);
        chk("jump10_y", ypos, 91);
        key(7'h20, 1'b0);
        key(7'h20, 1'b1);
        do_ticks(23);
        chk("jump33_y", ypos, 68);
        do_ticks(32);
        chk("jump65_y", ypos, 100);
        chk("jump65_air", airborne, 0);
        do_ticks(40);
        chk("nojump2_y", ypos, 100);
        chk("nojump2_air", airborne, 0);

        key(7'h57, 1'b0);
        key(7'h57, 1'b1);
        key(7'h64, 1'b0);
        do_ticks(21);
        chk("midjump_y", ypos, 80);
        chk("midjump_x", xpos, 42);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rstjump_y", ypos, 100);
        chk("rstjump_x", xpos, 40);
        chk("rstjump_air", airborne, 0);

        @(negedge clk);
        key_valid = 1'b1; key_code = 7'h44; released = 1'b0; tick = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; tick = 1'b0;
        do_ticks(9);
        chk("simul9_x", xpos, 40);
        do_ticks(1);
        chk("simul10_x", xpos, 41);
        repeat (5) @(negedge clk);
        chk("hold_x", xpos, 41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Sequences the player sprite's position from keyboard make/break events.
- Keeps per-key held state and paces horizontal steps with a tick divider.
- Runs a ground/rise/fall jump state machine and clamps position to the playfield.
- Sits between the keyboard decoder (ASCII key code + release flag) and the sprite draw stage; its xpos/ypos feed the renderer directly.

Parameters:
- X_MIN, 0, leftmost allowed xpos
- X_MAX, 1000, rightmost allowed xpos
- X_INIT, 40, xpos after reset
- Y_GROUND, 100, ground-level ypos (screen coords, y grows downward)
- STEP_DIV, 10, ticks per 1-pixel horizontal step (>=1)
- JUMP_HEIGHT, 32, pixels risen before falling (>=1, < Y_GROUND)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe: key_code/released valid this cycle
- key_code  in  7  ASCII code of the key event
- released  in  1  1 = key break (release), 0 = key make (press); sampled only with key_valid
- tick  in  1  one-cycle motion-enable pulse (e.g. once per frame)
- xpos  out  12  player x position, registered
- ypos  out  12  player y position, registered
- facing_left  out  1  last horizontal direction moved: 1 = left, 0 = right
- airborne  out  1  1 while jump FSM is in RISE or FALL

Behaviour:
- Reset values:
  - xpos = X_INIT, ypos = Y_GROUND, facing_left = 0, airborne = 0.
  - FSM = GROUND; held flags, jump request, step divider and rise counter all 0.
  - Reset mid-jump returns to ground on the next cycle.
- Key decode (case-insensitive):
  - 0x44/0x64 'D' = right.
  - 0x41/0x61 'A' = left.
  - 0x57/0x77 'W' or 0x20 space = jump.
  - All other codes are ignored.
- Held flags:
  - key_valid && !released sets the matching held flag.
  - key_valid && released clears it.
  - New flag value is visible from the next cycle.
- Jump request:
  - Set by a jump press while FSM = GROUND.
  - A press while airborne is discarded, with no buffering.
  - Jump release has no effect.
- Horizontal direction:
  - right only = +1; left only = -1.
  - Both held or neither held = none.
- Step divider (advances only on tick):
  - Direction none: divider clears to 0.
  - Otherwise, if divider == STEP_DIV-1: apply a 1-pixel step, clear divider.
  - Otherwise: divider increments.
  - First step occurs on the STEP_DIV-th tick after the direction becomes active.
  - Direction reversal does not clear the divider.
- Step application:
  - xpos += dir, saturating at X_MIN and X_MAX; never wraps.
  - facing_left updates on every step attempt, including a clamped one.
- Jump FSM (transitions only on tick):
  - GROUND: if jump request, go to RISE, clear request, rise_cnt = 0. ypos unchanged this tick.
  - RISE: ypos -= 1, rise_cnt += 1. When rise_cnt reaches JUMP_HEIGHT (after the decrement), go to FALL.
  - FALL: ypos += 1. When ypos reaches Y_GROUND, go to GROUND.
- airborne = (state != GROUND), registered.
- Horizontal motion is independent of the jump FSM and continues while airborne.
- Latency: all outputs update in the cycle after the tick that causes them.
- Simultaneous key_valid and tick: the tick uses the held flags and request registered before this cycle; the key event affects the following tick.
- Without tick, outputs hold indefinitely.

Test Plan:
- Reset, no input, 50 ticks -> xpos = 40, ypos = 100, airborne = 0, facing_left = 0.
- Press 'd' (0x64), 25 ticks -> xpos = 42 after tick 20, divider at 5. Release, 10 ticks -> xpos stays 42.
- Press 'A' and 'd' together, 30 ticks -> xpos unchanged. Release 'd', 10 ticks -> xpos decrements by 1, facing_left = 1.
- Start at xpos = 40, hold left 500 ticks -> xpos saturates at 0 after 400 ticks and never wraps to 4095.
- Press space on ground -> airborne = 1 on the next tick, ypos decreases to 68 after 33 ticks total, returns to 100 after 65 ticks, airborne = 0. A second space press at tick 10 is ignored (only one jump occurs).
- Assert rst at ypos = 80 during RISE -> next cycle ypos = 100, xpos = 40, airborne = 0. key_valid coinciding with tick -> that tick's step uses the old flags.
